// File: rtl/sprite_motion_engine.sv
// Frame-tick game state: player/enemy motion, bullet flight/hit FSM and hit score.
// Define ENEMY_DESCEND_EN to make the enemy descend on each wall bounce and enable game_over.
module sprite_motion_engine #(
  parameter int X_MIN         = 21,
  parameter int X_MAX         = 609,
  parameter int PLAYER_X_INIT = 320,
  parameter int PLAYER_Y      = 440,
  parameter int ENEMY_X_INIT  = 320,
  parameter int ENEMY_Y_INIT  = 40,
  parameter int PLAYER_STEP   = 4,
  parameter int ENEMY_STEP    = 2,
  parameter int BULLET_STEP   = 8,
  parameter int BULLET_Y_MIN  = 20,
  parameter int HIT_TICKS     = 16,
  parameter int PARK_X        = 1000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       tick,
  input  logic       left,
  input  logic       right,
  input  logic       stop,
  input  logic       shoot,
  output logic [9:0] playerXPosition,
  output logic [8:0] playerYPosition,
  output logic [9:0] enemyXPosition,
  output logic [8:0] enemyYPosition,
  output logic [9:0] bulletXPosition,
  output logic [8:0] bulletYPosition,
  output logic       bullet_active,
  output logic       hit,
  output logic [7:0] score,
  output logic       game_over
);

  typedef enum logic [1:0] {IDLE, FLYING, HIT} state_t;
  typedef enum logic [1:0] {DIR_IDLE, DIR_LEFT, DIR_RIGHT} dir_t;

  localparam int HCW = (HIT_TICKS > 1) ? $clog2(HIT_TICKS) : 1;

  state_t         state;
  dir_t           playerDir;
  logic           enemyLeft;
  logic           firePending;
  logic [HCW-1:0] hitCount;

  logic [10:0] playerSum;
  logic [9:0]  playerNext;
  logic [10:0] enemySum;
  logic [9:0]  enemyNext;
  logic        enemyLeftNext;
  logic        enemyBounce;
  logic        overlap;
  logic        enemyMoves;

  assign playerYPosition = 9'(PLAYER_Y);
  assign bullet_active   = (state == FLYING);

`ifndef ENEMY_DESCEND_EN
  assign enemyYPosition = 9'(ENEMY_Y_INIT);
  assign game_over      = 1'b0;
`endif

  // Player step and enemy patrol are computed in 11 bits so the clamp sees overshoot.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path infers a latch.
    playerSum     = {1'b0, playerXPosition};
    enemySum      = {1'b0, enemyXPosition};
    enemyLeftNext = enemyLeft;
    enemyBounce   = 1'b0;

    case (playerDir)
      DIR_LEFT:  playerSum = playerSum - 11'(PLAYER_STEP);
      DIR_RIGHT: playerSum = playerSum + 11'(PLAYER_STEP);
      default:   ;
    endcase
    if (playerSum < 11'(X_MIN))      playerNext = 10'(X_MIN);
    else if (playerSum > 11'(X_MAX)) playerNext = 10'(X_MAX);
    else                             playerNext = playerSum[9:0];

    if (enemyLeft) enemySum = enemySum - 11'(ENEMY_STEP);
    else           enemySum = enemySum + 11'(ENEMY_STEP);
    if (enemySum >= 11'(X_MAX)) begin
      enemyNext     = 10'(X_MAX);
      enemyLeftNext = 1'b1;
      enemyBounce   = 1'b1;
    end else if (enemySum <= 11'(X_MIN)) begin
      enemyNext     = 10'(X_MIN);
      enemyLeftNext = 1'b0;
      enemyBounce   = 1'b1;
    end else begin
      enemyNext     = enemySum[9:0];
    end

    // Bullet [bx,bx+10)x[by,by+10) against enemy [ex-10,ex+20)x[ey,ey+20).
    overlap = ({1'b0, bulletXPosition} + 11'd20 > {1'b0, enemyXPosition}) &&
              ({1'b0, bulletXPosition} < {1'b0, enemyXPosition} + 11'd20) &&
              ({1'b0, bulletYPosition} + 10'd10 > {1'b0, enemyYPosition}) &&
              ({1'b0, bulletYPosition} < {1'b0, enemyYPosition} + 10'd20);

    enemyMoves = tick && !game_over && (state != HIT) && !((state == FLYING) && overlap);
  end

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      playerXPosition <= 10'(PLAYER_X_INIT);
      enemyXPosition  <= 10'(ENEMY_X_INIT);
      bulletXPosition <= 10'(PARK_X);
      bulletYPosition <= 9'd0;
      enemyLeft       <= 1'b0;
      playerDir       <= DIR_IDLE;
      state           <= IDLE;
      firePending     <= 1'b0;
      hitCount        <= '0;
      hit             <= 1'b0;
      score           <= 8'd0;
`ifdef ENEMY_DESCEND_EN
      enemyYPosition  <= 9'(ENEMY_Y_INIT);
      game_over       <= 1'b0;
`endif
    end else begin
      hit <= 1'b0;

      if (stop)       playerDir <= DIR_IDLE;
      else if (left)  playerDir <= DIR_LEFT;
      else if (right) playerDir <= DIR_RIGHT;

      if (!game_over) begin
        if ((state == IDLE) && shoot) firePending <= 1'b1;
        if (tick) playerXPosition <= playerNext;

        if (enemyMoves) begin
          enemyXPosition <= enemyNext;
          enemyLeft      <= enemyLeftNext;
`ifdef ENEMY_DESCEND_EN
          if (enemyBounce) begin
            enemyYPosition <= enemyYPosition + 9'd10;
            if ({1'b0, enemyYPosition} + 10'd30 >= 10'(PLAYER_Y - 10)) game_over <= 1'b1;
          end
`endif
        end

        if (tick) begin
          case (state)
            IDLE: begin
              if (firePending || shoot) begin
                bulletXPosition <= playerXPosition;
                bulletYPosition <= 9'(PLAYER_Y - 20);
                firePending     <= 1'b0;
                state           <= FLYING;
              end
            end
            FLYING: begin
              if (overlap) begin
                hit             <= 1'b1;
                if (score != 8'hFF) score <= score + 8'd1;
                bulletXPosition <= 10'(PARK_X);
                bulletYPosition <= 9'd0;
                enemyXPosition  <= 10'(ENEMY_X_INIT);
                firePending     <= 1'b0;
                hitCount        <= '0;
                state           <= HIT;
              end else if (bulletYPosition < 9'(BULLET_Y_MIN + BULLET_STEP)) begin
                bulletXPosition <= 10'(PARK_X);
                bulletYPosition <= 9'd0;
                state           <= IDLE;
              end else begin
                bulletYPosition <= bulletYPosition - 9'(BULLET_STEP);
              end
            end
            HIT: begin
              if (hitCount == HCW'(HIT_TICKS - 1)) state <= IDLE;
              hitCount <= hitCount + 1'b1;
            end
            default: state <= IDLE;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_sprite_motion_engine.sv
// Randomised and directed bench for sprite_motion_engine against a rule-level game model.
module tb_sprite_motion_engine;

  localparam int X_MIN = 21, X_MAX = 609, P_INIT = 320, P_Y = 440;
  localparam int E_INIT = 320, E_Y = 40, P_STEP = 4, E_STEP = 2, B_STEP = 8;
  localparam int B_YMIN = 20, H_TICKS = 16, PARK = 1000;

  logic clock = 1'b0, reset = 1'b1;
  logic tick = 1'b0, left = 1'b0, right = 1'b0, stop = 1'b0, shoot = 1'b0;
  logic [9:0] playerXPosition, enemyXPosition, bulletXPosition;
  logic [8:0] playerYPosition, enemyYPosition, bulletYPosition;
  logic       bullet_active, hit, game_over;
  logic [7:0] score;

  int checks = 0;
  int errors = 0;

  // Game model: positions as plain integers, mode 0=idle 1=flying 2=hit.
  int mPX, mEX, mEY, mBX, mBY, mEDir, mPDir, mMode, mHcnt, mScore, mBounces;
  bit mPend, mHit, mGo;

  always #10 clock = ~clock;

  sprite_motion_engine dut (
    .clock(clock), .reset(reset), .tick(tick), .left(left), .right(right),
    .stop(stop), .shoot(shoot),
    .playerXPosition(playerXPosition), .playerYPosition(playerYPosition),
    .enemyXPosition(enemyXPosition), .enemyYPosition(enemyYPosition),
    .bulletXPosition(bulletXPosition), .bulletYPosition(bulletYPosition),
    .bullet_active(bullet_active), .hit(hit), .score(score), .game_over(game_over)
  );

  wire [67:0] dutVec = {playerXPosition, playerYPosition, enemyXPosition, enemyYPosition,
                        bulletXPosition, bulletYPosition, bullet_active, hit, score, game_over};

  function automatic logic [67:0] modelVec();
    return {10'(mPX), 9'(P_Y), 10'(mEX), 9'(mEY), 10'(mBX), 9'(mBY),
            (mMode == 1), mHit, 8'(mScore), mGo};
  endfunction

  function automatic int imax(int a, int b); return (a > b) ? a : b; endfunction
  function automatic int imin(int a, int b); return (a < b) ? a : b; endfunction

  task automatic model_reset();
    mPX = P_INIT; mEX = E_INIT; mEY = E_Y; mBX = PARK; mBY = 0;
    mEDir = 1; mPDir = 0; mMode = 0; mHcnt = 0; mScore = 0; mBounces = 0;
    mPend = 0; mHit = 0; mGo = 0;
  endtask

  task automatic model_step(input bit t, input bit l, input bit r, input bit s, input bit sh);
    int opx, obx, oby, oex, oey;
    bit enemyMoves, bounce;
    opx = mPX; obx = mBX; oby = mBY; oex = mEX; oey = mEY;
    mHit = 0;
    if (!mGo) begin
      if (t) begin
        mPX = imin(X_MAX, imax(X_MIN, mPX + P_STEP * mPDir));
        enemyMoves = (mMode != 2);
        bounce = 0;
        case (mMode)
          0: if (mPend || sh) begin
               mBX = opx; mBY = P_Y - 20; mPend = 0; mMode = 1;
             end
          1: if (imax(obx, oex - 10) < imin(obx + 10, oex + 20) &&
                 imax(oby, oey) < imin(oby + 10, oey + 20)) begin
               mHit = 1; mScore = imin(255, mScore + 1);
               mBX = PARK; mBY = 0; mEX = E_INIT; mMode = 2; mHcnt = 0; mPend = 0;
               enemyMoves = 0;
             end else if (oby < B_YMIN + B_STEP) begin
               mBX = PARK; mBY = 0; mMode = 0;
             end else begin
               mBY = oby - B_STEP;
             end
          default: begin
            mHcnt++;
            if (mHcnt == H_TICKS) mMode = 0;
          end
        endcase
        if (enemyMoves) begin
          mEX = mEX + E_STEP * mEDir;
          if (mEX >= X_MAX)      begin mEX = X_MAX; mEDir = -1; bounce = 1; end
          else if (mEX <= X_MIN) begin mEX = X_MIN; mEDir = 1;  bounce = 1; end
        end
`ifdef ENEMY_DESCEND_EN
        if (bounce) begin mEY += 10; mBounces++; end
        if (mEY + 20 >= P_Y - 10) mGo = 1;
`else
        if (bounce) mBounces++;
`endif
      end else if (mMode == 0 && sh) begin
        mPend = 1;
      end
    end
    if (s)      mPDir = 0;
    else if (l) mPDir = -1;
    else if (r) mPDir = 1;
  endtask

  // One clock: inputs applied away from the edge, model advanced at the edge, outputs sampled 1 after.
  task automatic drive(input bit t, input bit l, input bit r, input bit s, input bit sh);
    tick = t; left = l; right = r; stop = s; shoot = sh;
    @(posedge clock);
    model_step(t, l, r, s, sh);
    #1;
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    tick = 0; left = 0; right = 0; stop = 0; shoot = 0;
    #5;
    model_reset();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    @(posedge clock); #1;
    apply_reset();
    checks++;
    if (dutVec !== modelVec()) begin
      errors++; $display("FAIL reset_state: dut=%h model=%h", dutVec, modelVec());
    end
    checks++;
    if (playerYPosition !== 9'd440 || bullet_active !== 1'b0) begin
      errors++; $display("FAIL reset_fixed: playerY=%0d active=%0b expected 440/0", playerYPosition, bullet_active);
    end
  endtask

  task automatic test_player_clamp();
    apply_reset();
    drive(0, 0, 1, 0, 0);
    for (int i = 0; i < 100; i++) begin
      drive(1, 0, 1, 0, 0);
      checks++;
      if (dutVec !== modelVec()) begin
        errors++; $display("FAIL clamp_model tick %0d: dut=%h model=%h", i, dutVec, modelVec());
      end
      if (i == 71 || i == 72) begin
        checks++;
        if (playerXPosition !== ((i == 71) ? 10'd608 : 10'd609)) begin
          errors++; $display("FAIL clamp_reach tick %0d: got %0d", i + 1, playerXPosition);
        end
      end
    end
    checks++;
    if (playerXPosition !== 10'd609) begin
      errors++; $display("FAIL clamp_hold: got %0d expected 609", playerXPosition);
    end
    drive(0, 1, 0, 0, 0);
    drive(1, 1, 0, 0, 0);
    checks++;
    if (playerXPosition !== 10'd605) begin
      errors++; $display("FAIL clamp_left: got %0d expected 605", playerXPosition);
    end
    drive(0, 0, 0, 1, 0);
  endtask

  task automatic test_fire_and_retire();
    apply_reset();
    drive(0, 0, 0, 0, 1);
    drive(0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0);
    checks++;
    if (bulletXPosition !== 10'd320 || bulletYPosition !== 9'd420 || bullet_active !== 1'b1) begin
      errors++; $display("FAIL fire_launch: got (%0d,%0d,%0b) expected (320,420,1)",
                         bulletXPosition, bulletYPosition, bullet_active);
    end
    drive(0, 0, 0, 0, 1);
    for (int i = 0; i < 50; i++) begin
      drive(1, 0, 0, 0, 0);
      checks++;
      if (dutVec !== modelVec()) begin
        errors++; $display("FAIL fire_model tick %0d: dut=%h model=%h", i, dutVec, modelVec());
      end
    end
    checks++;
    if (bulletYPosition !== 9'd20 || bullet_active !== 1'b1) begin
      errors++; $display("FAIL fire_last_step: got y=%0d active=%0b expected 20/1", bulletYPosition, bullet_active);
    end
    drive(1, 0, 0, 0, 0);
    checks++;
    if (bullet_active !== 1'b0 || bulletXPosition !== 10'd1000) begin
      errors++; $display("FAIL fire_retire: got active=%0b x=%0d expected 0/1000", bullet_active, bulletXPosition);
    end
    for (int i = 0; i < 5; i++) drive(1, 0, 0, 0, 0);
    checks++;
    if (bullet_active !== 1'b0) begin
      errors++; $display("FAIL fire_no_refire: got active=%0b expected 0", bullet_active);
    end
  endtask

  task automatic test_hit();
    bit seen;
    apply_reset();
    drive(0, 0, 1, 0, 0);
    for (int i = 0; i < 47; i++) drive(1, 0, 1, 0, 0);
    drive(0, 0, 0, 1, 1);
    seen = 0;
    for (int i = 0; i < 60 && !seen; i++) begin
      drive(1, 0, 0, 0, 0);
      checks++;
      if (dutVec !== modelVec()) begin
        errors++; $display("FAIL hit_model tick %0d: dut=%h model=%h", i, dutVec, modelVec());
      end
      seen = (hit === 1'b1);
      if (!seen) drive(0, 0, 0, 0, 0);
    end
    checks++;
    if (!seen) begin
      errors++; $display("FAIL hit_timeout: no hit within 60 ticks, expected one");
    end
    checks++;
    if (score !== 8'd1 || enemyXPosition !== 10'd320 || bullet_active !== 1'b0) begin
      errors++; $display("FAIL hit_effects: got score=%0d ex=%0d active=%0b expected 1/320/0",
                         score, enemyXPosition, bullet_active);
    end
    drive(0, 0, 0, 0, 1);
    checks++;
    if (hit !== 1'b0) begin
      errors++; $display("FAIL hit_pulse_width: got %0b expected 0", hit);
    end
    for (int i = 0; i < H_TICKS - 1; i++) drive(1, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 1);
    checks++;
    if (enemyXPosition !== 10'd320 || dutVec !== modelVec()) begin
      errors++; $display("FAIL hit_frozen: ex=%0d dut=%h model=%h", enemyXPosition, dutVec, modelVec());
    end
    drive(1, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0);
    checks++;
    if (bullet_active !== 1'b0) begin
      errors++; $display("FAIL hit_refused: got active=%0b expected 0", bullet_active);
    end
    drive(0, 0, 0, 0, 1);
    drive(1, 0, 0, 0, 0);
    checks++;
    if (bullet_active !== 1'b1 || bulletXPosition !== 10'd508 || dutVec !== modelVec()) begin
      errors++; $display("FAIL hit_refire: active=%0b bx=%0d expected 1/508", bullet_active, bulletXPosition);
    end
  endtask

  task automatic test_enemy_bounce();
    int n;
    apply_reset();
    n = 0;
    while (!(mEX == 607 && mEDir == 1) && n < 1200) begin
      drive(1, 0, 0, 0, 0);
      n++;
    end
    checks++;
    if (n >= 1200 || dutVec !== modelVec()) begin
      errors++; $display("FAIL bounce_approach: ticks=%0d dut=%h model=%h", n, dutVec, modelVec());
    end
    drive(1, 0, 0, 0, 0);
    checks++;
    if (enemyXPosition !== 10'd609) begin
      errors++; $display("FAIL bounce_clamp: got %0d expected 609", enemyXPosition);
    end
    drive(1, 0, 0, 0, 0);
    checks++;
    if (enemyXPosition !== 10'd607) begin
      errors++; $display("FAIL bounce_turn: got %0d expected 607", enemyXPosition);
    end
  endtask

  task automatic test_random();
    int bad;
    apply_reset();
    bad = 0;
    for (int i = 0; i < 3000; i++) begin
      drive($urandom_range(0, 2) == 0, $urandom_range(0, 7) == 0, $urandom_range(0, 5) == 0,
            $urandom_range(0, 15) == 0, $urandom_range(0, 19) == 0);
      checks++;
      if (dutVec !== modelVec()) begin
        errors++; bad++;
        if (bad <= 10) $display("FAIL random cycle %0d: dut=%h model=%h", i, dutVec, modelVec());
      end
    end
  endtask

  task automatic test_reset_midflight();
    for (int i = 0; i < 60; i++) drive(1, 0, 0, 1, 0);
    drive(0, 0, 1, 0, 1);
    for (int i = 0; i < 4; i++) drive(1, 0, 1, 0, 0);
    checks++;
    if (bullet_active !== 1'b1 || mMode != 1) begin
      errors++; $display("FAIL midflight_setup: active=%0b expected 1", bullet_active);
    end
    reset = 1'b1;
    @(posedge clock); #1;
    checks++;
    if (bulletXPosition !== 10'd1000 || playerXPosition !== 10'd320 || enemyXPosition !== 10'd320 ||
        score !== 8'd0 || bullet_active !== 1'b0) begin
      errors++; $display("FAIL midflight_reset: bx=%0d px=%0d ex=%0d score=%0d active=%0b expected 1000/320/320/0/0",
                         bulletXPosition, playerXPosition, enemyXPosition, score, bullet_active);
    end
    apply_reset();
  endtask

`ifdef ENEMY_DESCEND_EN
  task automatic test_descend();
    logic [67:0] frozen;
    int n;
    apply_reset();
    n = 0;
    while (mBounces < 19 && n < 20000) begin drive(1, 0, 0, 0, 0); n++; end
    checks++;
    if (enemyYPosition !== 9'd230 || dutVec !== modelVec()) begin
      errors++; $display("FAIL descend_19: ey=%0d expected 230 dut=%h model=%h", enemyYPosition, dutVec, modelVec());
    end
    n = 0;
    while (!mGo && n < 20000) begin drive(1, 0, 0, 0, 0); n++; end
    checks++;
    if (game_over !== 1'b1 || dutVec !== modelVec()) begin
      errors++; $display("FAIL descend_game_over: go=%0b dut=%h model=%h", game_over, dutVec, modelVec());
    end
    frozen = dutVec;
    for (int i = 0; i < 5; i++) drive(1, 0, 1, 0, 1);
    checks++;
    if (dutVec !== frozen) begin
      errors++; $display("FAIL descend_frozen: dut=%h expected %h", dutVec, frozen);
    end
  endtask
`endif

  initial begin
    model_reset();
    test_reset();
    test_player_clamp();
    test_fire_and_retire();
    test_hit();
    test_enemy_bounce();
    test_random();
    test_reset_midflight();
`ifdef ENEMY_DESCEND_EN
    test_descend();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
